// File: rtl/axi_rd_burst_slave.sv
// AXI4 read burst slave: accepts one AR burst at a time and streams beats from a
// synchronous-read word memory. Optional error checking under AXI_RD_ERR_CHECK_EN.
module axi_rd_burst_slave #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [1:0]        ARBURST,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              mem_rd_en,
  output logic [ADDR_W-3:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int WA = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;
  typedef enum logic [1:0] {K_FIXED = 2'b00, K_INCR = 2'b01, K_WRAP = 2'b10} kind_t;

  state_t           state, state_n;
  kind_t            kind_q, kind_d;
  logic             ar_ready_q;
  logic [ID_W-1:0]  id_q;
  logic [WA-1:0]    addr_q, next_addr, wrap_mask;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   cnt_q;
  logic             err_q, err_d;
  logic             ar_hs, r_hs, last, wrap_ok;
  logic             unused_ok;

  assign unused_ok = ^{ARSIZE, ARADDR[1:0], 1'b0};

  assign ar_hs   = ARVALID & ar_ready_q;
  assign r_hs    = (state == DATA) & RREADY;
  assign last    = (cnt_q == {1'b0, len_q});
  assign wrap_ok = (ARLEN == LEN_W'(1)) | (ARLEN == LEN_W'(3)) |
                   (ARLEN == LEN_W'(7)) | (ARLEN == LEN_W'(15));

  // Reserved and badly-sized WRAP bursts fall back to INCR address generation.
  always_comb begin
    kind_d = K_INCR;
    if (ARBURST == 2'b00)
      kind_d = K_FIXED;
    else if (ARBURST == 2'b10 && wrap_ok)
      kind_d = K_WRAP;
  end

`ifdef AXI_RD_ERR_CHECK_EN
  assign err_d = (ARSIZE != 3'd2) | (ARBURST == 2'b11) | ((ARBURST == 2'b10) & !wrap_ok);
`else
  assign err_d = 1'b0;
`endif

  // For legal WRAP lengths, ARLEN itself is the word-offset wrap mask.
  assign wrap_mask = WA'(len_q);

  always_comb begin
    next_addr = addr_q;
    case (kind_q)
      K_FIXED: next_addr = addr_q;
      K_WRAP:  next_addr = (addr_q & ~wrap_mask) | ((addr_q + WA'(1)) & wrap_mask);
      default: next_addr = addr_q + WA'(1);
    endcase
  end

  always_comb begin
    state_n     = state;
    mem_rd_en   = 1'b0;
    mem_rd_addr = addr_q;
    case (state)
      IDLE: begin
        if (ar_hs)
          state_n = ISSUE;
      end
      ISSUE: begin
        mem_rd_en = !err_q;
        state_n   = DATA;
      end
      DATA: begin
        if (r_hs) begin
          if (last) begin
            state_n = IDLE;
          end else begin
            mem_rd_en   = !err_q;
            mem_rd_addr = next_addr;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ar_ready_q <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      kind_q     <= K_INCR;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      ar_ready_q <= (state_n == IDLE);
      if (ar_hs) begin
        id_q   <= ARID;
        addr_q <= ARADDR[ADDR_W-1:2];
        len_q  <= ARLEN;
        kind_q <= kind_d;
        cnt_q  <= '0;
        err_q  <= err_d;
      end else if (r_hs && !last) begin
        addr_q <= next_addr;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  // Memory output is held while mem_rd_en is low, so RDATA stays stable under stall.
  assign ARREADY = ar_ready_q;
  assign RVALID  = (state == DATA);
  assign RID     = id_q;
  assign RLAST   = RVALID & last;
  assign RDATA   = (RVALID && !err_q) ? mem_rd_data : '0;
  assign RRESP   = (RVALID && err_q) ? 2'b10 : 2'b00;

endmodule
